clock_enable_controller: RTL

Sequences the processor's clock from the FPGA board clock in place of a free-running divided clock. It produces a single-cycle clock-enable pulse (`tick_en`) at a programmable rate and supports run, single-step, halt-on-request and stop. The divisor can be updated at run time. The processor core and its peripherals stay on `clock_in` and qualify their state updates with `tick_en`.

---
 rtl/clock_enable_controller.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/clock_enable_controller.sv
// -----------------------------------------------------------------------------
// clock_enable_controller
//
// Sequences the processor clock from the board clock. The core stays on
// clock_in and qualifies its state updates with tick_en. This block issues a
// single-cycle tick_en pulse every max(divisor, 1) cycles. It supports
// free-run, single-step, halt-on-request and stop. The divisor can be
// reprogrammed at run time.
//
// Ports
//   clock_in    in   board clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   run_req     in   level, free-run requested
//   step_req    in   pulse, request exactly one tick (only honoured in STOPPED)
//   halt_req    in   level from the core, stop issuing ticks
//   div_wr      in   strobe, capture div_data as the pending divisor
//   div_data    in   new divisor value
//   div_ack     out  one-cycle pulse when the pending divisor became active
//   tick_en     out  registered one-cycle clock enable to the core
//   state       out  0 STOPPED, 1 RUNNING, 2 STEPPING, 3 HALTED
//   tick_count  out  number of tick_en pulses since reset, wraps at 2^32
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+------------------------------------------------------------------
// STOPPED  | idle; waits for run_req or step_req, applies pending divisor
// RUNNING  | free-run, one tick every eff cycles while run_req stays high
// STEPPING | one interval, one tick, then back to STOPPED
// HALTED   | core requested halt; leaves only once run_req and halt_req are low
//
module clock_enable_controller #(
    parameter int unsigned              CNT_WIDTH       = 28,
    parameter logic [CNT_WIDTH-1:0]     DEFAULT_DIVISOR = CNT_WIDTH'(5)
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    input  logic                 run_req,
    input  logic                 step_req,
    input  logic                 halt_req,
    input  logic                 div_wr,
    input  logic [CNT_WIDTH-1:0] div_data,
    output logic                 div_ack,
    output logic                 tick_en,
    output logic [1:0]           state,
    output logic [31:0]          tick_count
);

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

    state_e                 state_q,        state_d;
    logic [CNT_WIDTH-1:0]   cnt_q,          cnt_d;
    logic [CNT_WIDTH-1:0]   div_q,          div_d;
    logic [CNT_WIDTH-1:0]   pend_div_q,     pend_div_d;
    logic                   pend_q,         pend_d;
    logic                   tick_q,         tick_d;
    logic                   ack_q,          ack_d;
    logic [31:0]            tick_count_q,   tick_count_d;

    logic [CNT_WIDTH-1:0]   last_cnt;
    logic                   counting;
    logic                   wrap;
    logic                   entering;
    logic                   apply_div;

    // A programmed divisor of 0 behaves as 1, so the terminal count is
    // divisor-1 clamped at 0 and never underflows.
    always_comb begin
        last_cnt = '0;
        if (div_q != '0) begin
            last_cnt = div_q - CNT_WIDTH'(1);
        end
    end

    assign counting = (state_q == ST_RUNNING) || (state_q == ST_STEPPING);
    assign wrap     = counting && (cnt_q == last_cnt);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic, priority halt_req > run_req > step_req
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOPPED: begin
                // halt_req has no meaning while nothing is being issued.
                if (run_req) begin
                    state_d = ST_RUNNING;
                end else if (step_req) begin
                    state_d = ST_STEPPING;
                end
            end
            ST_RUNNING: begin
                if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (!run_req) begin
                    state_d = ST_STOPPED;
                end
            end
            ST_STEPPING: begin
                // run_req is deliberately not looked at until the step is done.
                if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (wrap) begin
                    state_d = ST_STOPPED;
                end
            end
            ST_HALTED: begin
                // Resuming needs run dropped first, so a still-high run_req
                // cannot restart the core straight out of a halt.
                if (!run_req && !halt_req) begin
                    state_d = ST_STOPPED;
                end
            end
            default: state_d = ST_STOPPED;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath / output next values
    // -------------------------------------------------------------------------
    always_comb begin
        entering     = 1'b0;
        cnt_d        = '0;
        tick_d       = 1'b0;
        apply_div    = 1'b0;
        div_d        = div_q;
        pend_div_d   = pend_div_q;
        pend_d       = pend_q;
        ack_d        = 1'b0;
        tick_count_d = tick_count_q + 32'(tick_q);

        entering = (state_d != state_q) &&
                   ((state_d == ST_RUNNING) || (state_d == ST_STEPPING));

        // Each entry starts a fresh interval. Outside the counting states the
        // counter is held at 0.
        if (!entering && counting && (state_d == state_q)) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_WIDTH'(1);
        end

        // A wrap only produces a tick when no halt or run-drop happens in the
        // same cycle. The step's own wrap-to-STOPPED still ticks.
        if (wrap && !halt_req) begin
            if (state_q == ST_STEPPING) begin
                tick_d = 1'b1;
            end else if (run_req) begin
                tick_d = 1'b1;
            end
        end

        // While counting, the interval in progress completes on the old
        // divisor. When idle the change takes effect at once.
        if (pend_q) begin
            if ((state_q == ST_STOPPED) || (state_q == ST_HALTED) || wrap) begin
                apply_div = 1'b1;
            end
        end

        if (apply_div) begin
            div_d  = pend_div_q;
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end

        // A write landing on an application cycle is kept for the next one.
        if (div_wr) begin
            pend_div_d = div_data;
            pend_d     = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            div_q        <= DEFAULT_DIVISOR;
            pend_div_q   <= '0;
            pend_q       <= 1'b0;
            tick_q       <= 1'b0;
            ack_q        <= 1'b0;
            tick_count_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            pend_div_q   <= pend_div_d;
            pend_q       <= pend_d;
            tick_q       <= tick_d;
            ack_q        <= ack_d;
            tick_count_q <= tick_count_d;
        end
    end

    assign tick_en    = tick_q;
    assign div_ack    = ack_q;
    assign state      = state_q;
    assign tick_count = tick_count_q;

endmodule
